// File: rtl/pattern_src.sv
// pattern_src: programmable stream stimulus source.
// Emits a run of beats on a valid/ready stream. The run is split into
// bursts separated by idle gaps. Beat data follows one of four patterns:
// increment, Galois LFSR, constant, walking-one.
module pattern_src #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    CNT_WIDTH  = 16,
    parameter int                    BURST_LEN  = 4,
    parameter int                    GAP_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = 8'hB8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [CNT_WIDTH-1:0]  beats,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] odata,
    output logic                  ovalid,
    input  logic                  oready,
    output logic                  olast,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  beat_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

    localparam logic [1:0] M_INC   = 2'd0;
    localparam logic [1:0] M_LFSR  = 2'd1;
    localparam logic [1:0] M_CONST = 2'd2;
    localparam logic [1:0] M_WALK  = 2'd3;

    localparam int BC_W = (BURST_LEN  > 1) ? $clog2(BURST_LEN)  : 1;
    localparam int GC_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST_LEN - 1);
    localparam logic [GC_W-1:0] GAP_LAST   = GC_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t                  state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic [DATA_WIDTH-1:0]   seed_q, seed_d;
    logic [CNT_WIDTH-1:0]    beats_q, beats_d;
    logic [DATA_WIDTH-1:0]   odata_q, odata_d;
    logic                    ovalid_q, ovalid_d;
    logic                    olast_q, olast_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [CNT_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;
    logic [BC_W-1:0]         burst_q, burst_d;
    logic [GC_W-1:0]         gap_q, gap_d;

    logic                    xfer;
    logic [CNT_WIDTH-1:0]    cnt_inc;
    logic [DATA_WIDTH-1:0]   seed_eff;

    // Pattern step applied to the beat just transferred.
    function automatic logic [DATA_WIDTH-1:0] next_val(
        input logic [1:0]            m,
        input logic [DATA_WIDTH-1:0] v,
        input logic [DATA_WIDTH-1:0] s
    );
        logic [DATA_WIDTH-1:0] r;
        case (m)
            M_INC:   r = v + 1'b1;
            M_LFSR:  r = (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
            M_CONST: r = s;
            default: r = (v << 1) | (v >> (DATA_WIDTH - 1));
        endcase
        return r;
    endfunction

    // Run sequencing: start capture, burst/gap pacing, completion and abort.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        seed_d     = seed_q;
        beats_d    = beats_q;
        odata_d    = odata_q;
        ovalid_d   = ovalid_q;
        olast_d    = olast_q;
        done_d     = 1'b0;
        beat_cnt_d = beat_cnt_q;
        burst_d    = burst_q;
        gap_d      = gap_q;

        xfer    = ovalid_q & oready;
        cnt_inc = beat_cnt_q + 1'b1;
        // LFSR and walking-one lock up on zero, so a zero seed becomes 1.
        seed_eff = ((mode == M_LFSR || mode == M_WALK) && seed == '0)
                   ? DATA_WIDTH'(1) : seed;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    seed_d     = seed_eff;
                    beats_d    = beats;
                    beat_cnt_d = '0;
                    burst_d    = '0;
                    gap_d      = '0;
                    olast_d    = 1'b0;
                    if (beats == '0) begin
                        state_d  = S_DONE;
                        ovalid_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        state_d  = S_RUN;
                        ovalid_d = 1'b1;
                        odata_d  = seed_eff;
                        olast_d  = (beats == CNT_WIDTH'(1));
                    end
                end
            end
            S_RUN: begin
                if (xfer) begin
                    beat_cnt_d = cnt_inc;
                    if (cnt_inc == beats_q) begin
                        state_d  = S_DONE;
                        ovalid_d = 1'b0;
                        olast_d  = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        odata_d = next_val(mode_q, odata_q, seed_q);
                        olast_d = (cnt_inc == beats_q - 1'b1);
                        if (burst_q == BURST_LAST) begin
                            burst_d = '0;
                            if (GAP_CYCLES > 0) begin
                                state_d  = S_GAP;
                                ovalid_d = 1'b0;
                                olast_d  = 1'b0;
                                gap_d    = '0;
                            end
                        end else begin
                            burst_d = burst_q + 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d  = S_RUN;
                    ovalid_d = 1'b1;
                    olast_d  = (beat_cnt_q == beats_q - 1'b1);
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything except reset; a transfer in this
        // cycle has already been counted above.
        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            ovalid_d = 1'b0;
            olast_d  = 1'b0;
            done_d   = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            seed_q     <= '0;
            beats_q    <= '0;
            odata_q    <= '0;
            ovalid_q   <= 1'b0;
            olast_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            beat_cnt_q <= '0;
            burst_q    <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            seed_q     <= seed_d;
            beats_q    <= beats_d;
            odata_q    <= odata_d;
            ovalid_q   <= ovalid_d;
            olast_q    <= olast_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            beat_cnt_q <= beat_cnt_d;
            burst_q    <= burst_d;
            gap_q      <= gap_d;
        end
    end

    assign odata    = odata_q;
    assign ovalid   = ovalid_q;
    assign olast    = olast_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_pattern_src.sv
// Bench for pattern_src: two instances (gapped and gapless) share inputs;
// a collector records what the selected instance puts on the stream.
module tb_pattern_src;

    logic        sys_clk = 1'b0;
    logic        sys_rst, start, abort, oready;
    logic [1:0]  mode;
    logic [7:0]  seed;
    logic [15:0] beats;

    logic [7:0]  a_odata, z_odata, s_odata;
    logic        a_ovalid, z_ovalid, s_ovalid;
    logic        a_olast, z_olast, s_olast;
    logic        a_busy, z_busy, s_busy;
    logic        a_done, z_done, s_done;
    logic [15:0] a_cnt, z_cnt, s_cnt;
    bit          sel;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    pattern_src #(.DATA_WIDTH(8), .CNT_WIDTH(16), .BURST_LEN(4), .GAP_CYCLES(2), .LFSR_TAPS(8'hB8)) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .mode(mode), .seed(seed),
        .beats(beats), .abort(abort), .odata(a_odata), .ovalid(a_ovalid), .oready(oready),
        .olast(a_olast), .busy(a_busy), .done(a_done), .beat_cnt(a_cnt));

    pattern_src #(.DATA_WIDTH(8), .CNT_WIDTH(16), .BURST_LEN(4), .GAP_CYCLES(0), .LFSR_TAPS(8'hB8)) u_dut_nogap (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .mode(mode), .seed(seed),
        .beats(beats), .abort(abort), .odata(z_odata), .ovalid(z_ovalid), .oready(oready),
        .olast(z_olast), .busy(z_busy), .done(z_done), .beat_cnt(z_cnt));

    always_comb begin
        s_odata  = sel ? z_odata  : a_odata;
        s_ovalid = sel ? z_ovalid : a_ovalid;
        s_olast  = sel ? z_olast  : a_olast;
        s_busy   = sel ? z_busy   : a_busy;
        s_done   = sel ? z_done   : a_done;
        s_cnt    = sel ? z_cnt    : a_cnt;
    end

    // Reference pattern rules.
    function automatic logic [7:0] m_first(input int md, input logic [7:0] s);
        return ((md == 1 || md == 3) && s == 8'h00) ? 8'h01 : s;
    endfunction

    function automatic logic [7:0] m_step(input int md, input logic [7:0] v, input logic [7:0] s);
        int w;
        w = int'(v);
        case (md)
            0:       return 8'((w + 1) % 256);
            1:       return 8'((w / 2) ^ ((w % 2 == 1) ? 32'hB8 : 32'h0));
            2:       return s;
            default: return 8'((w * 2 + w / 128) % 256);
        endcase
    endfunction

    // Collector observations.
    logic [7:0] xv[$];
    bit         xl[$];
    int         xidle[$];
    int nx, last_x, done_cyc, done_cnt, stall_err, proto_err, cnt_err;
    bit timeout;
    logic pa_valid, pa_busy, busy_at_done, busy_after_done;

    // Pulse abort (no effect on idle units) to return both instances to IDLE, then start.
    task automatic do_start(input logic [1:0] m, input logic [7:0] s, input logic [15:0] b);
        abort = 1'b1; oready = 1'b0;
        @(posedge sys_clk); #1;
        abort = 1'b0;
        start = 1'b1; mode = m; seed = s; beats = b;
        @(posedge sys_clk); #1;
        start = 1'b0; mode = $urandom; seed = $urandom; beats = $urandom;
    endtask

    // rdy_pct < 0 means oready toggles 1,0,1,0...; abort_at < 0 means no abort.
    task automatic collect(input int abort_at, input int rdy_pct);
        int cyc = 0, idle = 0, abort_cyc = -1;
        bit fin = 0, pv = 0;
        logic [7:0] pd = 8'h00;
        logic pl = 1'b0;
        xv.delete(); xl.delete(); xidle.delete();
        nx = 0; last_x = -1; done_cyc = -1; done_cnt = 0;
        stall_err = 0; proto_err = 0; cnt_err = 0; timeout = 0;
        pa_valid = 1'bx; pa_busy = 1'bx; busy_at_done = 1'bx; busy_after_done = 1'bx;
        while (!fin) begin
            if (abort_at >= 0 && nx == abort_at && abort_cyc < 0) begin
                abort = 1'b1; oready = 1'b0; abort_cyc = cyc;
            end else begin
                abort = 1'b0;
                oready = (rdy_pct < 0) ? (cyc % 2 == 0) : ($urandom_range(99) < rdy_pct);
            end
            @(negedge sys_clk);
            if (pv && !(abort_cyc >= 0 && cyc == abort_cyc + 1))
                if (!s_ovalid || s_odata !== pd || s_olast !== pl) stall_err++;
            if (s_olast && !s_ovalid) proto_err++;
            if (s_cnt !== 16'(nx)) cnt_err++;
            if (s_done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = s_busy; end
            end
            if (s_ovalid && oready) begin
                xv.push_back(s_odata); xl.push_back(s_olast); xidle.push_back(idle);
                idle = 0; last_x = cyc; nx++;
            end else if (!s_ovalid) idle++;
            pv = s_ovalid && !oready; pd = s_odata; pl = s_olast;
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin busy_after_done = s_busy; fin = 1; end
            if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin pa_valid = s_ovalid; pa_busy = s_busy; end
            if (abort_cyc >= 0 && cyc >= abort_cyc + 4) fin = 1;
            if (cyc >= 400) begin timeout = 1; fin = 1; end
            cyc++;
            @(posedge sys_clk); #1;
        end
        abort = 1'b0; oready = 1'b0;
    endtask

    task automatic test_reset;
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        checks++; if (a_odata !== 8'h00)  begin errors++; $display("FAIL reset_odata got %0h exp 0", a_odata); end
        checks++; if (a_ovalid !== 1'b0)  begin errors++; $display("FAIL reset_ovalid got %0b exp 0", a_ovalid); end
        checks++; if (a_olast !== 1'b0)   begin errors++; $display("FAIL reset_olast got %0b exp 0", a_olast); end
        checks++; if (a_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %0b exp 0", a_busy); end
        checks++; if (a_done !== 1'b0)    begin errors++; $display("FAIL reset_done got %0b exp 0", a_done); end
        checks++; if (a_cnt !== 16'h0)    begin errors++; $display("FAIL reset_beat_cnt got %0h exp 0", a_cnt); end
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
    endtask

    task automatic test_inc_gap;
        logic [7:0] ev[6] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
        int         ei[6] = '{0, 0, 0, 0, 2, 0};
        sel = 0;
        do_start(2'd0, 8'hFE, 16'd6);
        collect(-1, 100);
        checks++; if (timeout || xv.size() != 6) begin errors++; $display("FAIL inc_count got %0d exp 6 (timeout %0b)", xv.size(), timeout); end
        for (int i = 0; i < 6 && i < xv.size(); i++) begin
            checks++; if (xv[i] !== ev[i]) begin errors++; $display("FAIL inc_data[%0d] got %0h exp %0h", i, xv[i], ev[i]); end
            checks++; if (xidle[i] != ei[i]) begin errors++; $display("FAIL inc_gap[%0d] got %0d exp %0d", i, xidle[i], ei[i]); end
            checks++; if (xl[i] != (i == 5)) begin errors++; $display("FAIL inc_olast[%0d] got %0b exp %0b", i, xl[i], i == 5); end
        end
        checks++; if (done_cnt != 1 || done_cyc != last_x + 1) begin errors++; $display("FAIL inc_done got cnt %0d at %0d exp 1 at %0d", done_cnt, done_cyc, last_x + 1); end
        checks++; if (busy_at_done !== 1'b1 || busy_after_done !== 1'b0) begin errors++; $display("FAIL inc_busy got %0b/%0b exp 1/0", busy_at_done, busy_after_done); end
        checks++; if (a_cnt !== 16'd6) begin errors++; $display("FAIL inc_beat_cnt got %0d exp 6", a_cnt); end
        checks++; if (stall_err + proto_err + cnt_err != 0) begin errors++; $display("FAIL inc_protocol got %0d/%0d/%0d exp 0", stall_err, proto_err, cnt_err); end
    endtask

    task automatic test_const_stall;
        sel = 0;
        do_start(2'd2, 8'h5A, 16'd3);
        collect(-1, -1);
        checks++; if (timeout || xv.size() != 3) begin errors++; $display("FAIL const_count got %0d exp 3", xv.size()); end
        foreach (xv[i]) begin
            checks++; if (xv[i] !== 8'h5A) begin errors++; $display("FAIL const_data[%0d] got %0h exp 5a", i, xv[i]); end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL const_stall_stable got %0d exp 0", stall_err); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL const_done got %0d exp 1", done_cnt); end
        checks++; if (a_cnt !== 16'd3) begin errors++; $display("FAIL const_beat_cnt got %0d exp 3", a_cnt); end
    endtask

    task automatic test_lfsr;
        logic [7:0] ev[6] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
        sel = 0;
        do_start(2'd1, 8'h01, 16'd6);
        collect(-1, 100);
        checks++; if (timeout || xv.size() != 6) begin errors++; $display("FAIL lfsr_count got %0d exp 6", xv.size()); end
        for (int i = 0; i < 6 && i < xv.size(); i++) begin
            checks++; if (xv[i] !== ev[i]) begin errors++; $display("FAIL lfsr_data[%0d] got %0h exp %0h", i, xv[i], ev[i]); end
        end
    endtask

    task automatic test_walk_nogap;
        logic [7:0] ev[9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        sel = 1;
        do_start(2'd3, 8'h00, 16'd9);
        collect(-1, 100);
        checks++; if (timeout || xv.size() != 9) begin errors++; $display("FAIL walk_count got %0d exp 9", xv.size()); end
        for (int i = 0; i < 9 && i < xv.size(); i++) begin
            checks++; if (xv[i] !== ev[i]) begin errors++; $display("FAIL walk_data[%0d] got %0h exp %0h", i, xv[i], ev[i]); end
            checks++; if (xidle[i] != 0) begin errors++; $display("FAIL walk_gap[%0d] got %0d exp 0", i, xidle[i]); end
        end
        checks++; if (z_cnt !== 16'd9) begin errors++; $display("FAIL walk_beat_cnt got %0d exp 9", z_cnt); end
    endtask

    task automatic test_abort;
        sel = 0;
        do_start(2'd0, 8'h10, 16'd10);
        collect(2, 100);
        checks++; if (timeout || xv.size() != 2) begin errors++; $display("FAIL abort_count got %0d exp 2", xv.size()); end
        checks++; if (pa_valid !== 1'b0 || pa_busy !== 1'b0) begin errors++; $display("FAIL abort_idle got valid %0b busy %0b exp 0/0", pa_valid, pa_busy); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", done_cnt); end
        checks++; if (a_cnt !== 16'd2) begin errors++; $display("FAIL abort_beat_cnt got %0d exp 2", a_cnt); end
        do_start(2'd0, 8'h33, 16'd0);
        collect(-1, 100);
        checks++; if (timeout || done_cyc != 0 || nx != 0) begin errors++; $display("FAIL zero_beats_done got cyc %0d xfers %0d exp 0/0", done_cyc, nx); end
        checks++; if (busy_at_done !== 1'b1 || busy_after_done !== 1'b0) begin errors++; $display("FAIL zero_beats_busy got %0b/%0b exp 1/0", busy_at_done, busy_after_done); end
    endtask

    task automatic test_reset_mid_gap;
        sel = 0;
        do_start(2'd0, 8'h30, 16'd10);
        oready = 1'b1;
        repeat (4) @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        checks++; if (a_ovalid !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL midgap_setup got valid %0b busy %0b exp 0/1", a_ovalid, a_busy); end
        sys_rst = 1'b1; start = 1'b1; mode = 2'd0; seed = 8'h44; beats = 16'd5;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0; start = 1'b0;
        @(negedge sys_clk);
        checks++; if ({a_odata, a_ovalid, a_olast, a_busy, a_done, a_cnt} !== 29'h0) begin
            errors++; $display("FAIL midgap_reset got d%0h v%0b l%0b b%0b dn%0b c%0h exp all 0", a_odata, a_ovalid, a_olast, a_busy, a_done, a_cnt);
        end
        repeat (3) begin
            @(negedge sys_clk);
            checks++; if (a_ovalid !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL midgap_start_ignored got valid %0b busy %0b exp 0/0", a_ovalid, a_busy); end
        end
        @(posedge sys_clk); #1;
        oready = 1'b0;
    endtask

    task automatic test_random;
        for (int r = 0; r < 16; r++) begin
            int md, nb, pct, g;
            logic [7:0] sd, v;
            sel = ($urandom_range(1) == 1);
            md  = $urandom_range(3);
            sd  = (r % 5 == 0) ? 8'h00 : 8'($urandom);
            nb  = $urandom_range(13);
            pct = $urandom_range(30, 100);
            g   = sel ? 0 : 2;
            do_start(2'(md), sd, 16'(nb));
            collect(-1, pct);
            checks++; if (timeout || xv.size() != nb) begin errors++; $display("FAIL rnd%0d_count got %0d exp %0d", r, xv.size(), nb); end
            v = m_first(md, sd);
            for (int i = 0; i < nb && i < xv.size(); i++) begin
                checks++;
                if (xv[i] !== v || xl[i] != (i == nb - 1) || xidle[i] != ((i > 0 && i % 4 == 0) ? g : 0)) begin
                    errors++;
                    $display("FAIL rnd%0d_beat[%0d] got d%0h l%0b gap%0d exp d%0h l%0b gap%0d (mode %0d)",
                             r, i, xv[i], xl[i], xidle[i], v, i == nb - 1, (i > 0 && i % 4 == 0) ? g : 0, md);
                end
                v = m_step(md, v, m_first(md, sd));
            end
            checks++; if (done_cnt != 1 || done_cyc != last_x + 1) begin errors++; $display("FAIL rnd%0d_done got cnt %0d at %0d exp 1 at %0d", r, done_cnt, done_cyc, last_x + 1); end
            checks++; if (stall_err + proto_err + cnt_err != 0) begin errors++; $display("FAIL rnd%0d_protocol got %0d/%0d/%0d exp 0", r, stall_err, proto_err, cnt_err); end
        end
    endtask

    initial begin
        sys_rst = 1'b1; start = 1'b0; abort = 1'b0; oready = 1'b0;
        mode = 2'd0; seed = 8'h00; beats = 16'd0; sel = 0;
        test_reset;
        test_inc_gap;
        test_const_stall;
        test_lfsr;
        test_walk_nogap;
        test_abort;
        test_reset_mid_gap;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
